// File: rtl/rr_mux2_pkg.sv
// rr_mux2_pkg: shared source ids, default widths and output-register states
package rr_mux2_pkg;
  typedef logic src_t;
  localparam src_t SRC_D0 = 1'b0;
  localparam src_t SRC_D1 = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/rr_mux2_arbiter_if.sv
// rr_mux2_arbiter_if: two requester streams, one output stream and debug counters
interface rr_mux2_arbiter_if #(
  parameter int WIDTH = rr_mux2_pkg::DEF_WIDTH,
  parameter int CNT_W = rr_mux2_pkg::DEF_CNT_W
);
  logic             d0_valid;
  logic [WIDTH-1:0] d0;
  logic             d0_ready;
  logic             d1_valid;
  logic [WIDTH-1:0] d1;
  logic             d1_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic             y_src;
  logic             y_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  modport master (
    output d0_valid, d0, d1_valid, d1, y_ready,
    input  d0_ready, d1_ready, y_valid, y, y_src, cnt0, cnt1
  );
  modport slave (
    input  d0_valid, d0, d1_valid, d1, y_ready,
    output d0_ready, d1_ready, y_valid, y, y_src, cnt0, cnt1
  );
endinterface

// File: rtl/mux2_bus.sv
// mux2_bus: WIDTH-bit 2:1 and-or select
module mux2_bus #(
  parameter int WIDTH = rr_mux2_pkg::DEF_WIDTH
) (
  input  logic             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = ({WIDTH{~s}} & d0) | ({WIDTH{s}} & d1);
endmodule

// File: rtl/rr_mux2_arbiter.sv
// rr_mux2_arbiter: round-robin 2:1 arbiter with registered output and saturating per-source counters
module rr_mux2_arbiter #(
  parameter int WIDTH = rr_mux2_pkg::DEF_WIDTH,
  parameter int CNT_W = rr_mux2_pkg::DEF_CNT_W
) (
  input logic              clk,
  input logic              rst,
  rr_mux2_arbiter_if.slave bus
);
  import rr_mux2_pkg::*;
  state_t           state, state_nx;
  src_t             prio, s, y_src_q;
  logic             load, grant;
  logic [WIDTH-1:0] mux_y, y_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  always_comb begin
    load = state == EMPTY || bus.y_ready;
    s = (bus.d0_valid && bus.d1_valid) ? prio : (bus.d1_valid ? SRC_D1 : SRC_D0);
    grant = !rst && load && (bus.d0_valid || bus.d1_valid);
    state_nx = (grant || !load) ? FULL : EMPTY;
  end
  mux2_bus #(.WIDTH(WIDTH)) u_mux (.s(s), .d0(bus.d0), .d1(bus.d1), .y(mux_y));
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      prio    <= SRC_D0;
      y_q     <= '0;
      y_src_q <= SRC_D0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        y_q     <= mux_y;
        y_src_q <= s;
        prio    <= ~s;
      end
      if (bus.d0_ready && !(&cnt0_q)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (bus.d1_ready && !(&cnt1_q)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end
  assign bus.d0_ready = grant && s == SRC_D0;
  assign bus.d1_ready = grant && s == SRC_D1;
  assign bus.y_valid  = state == FULL;
  assign bus.y        = y_q;
  assign bus.y_src    = y_src_q;
  assign bus.cnt0     = cnt0_q;
  assign bus.cnt1     = cnt1_q;
endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// tb_rr_mux2_arbiter: randomized self-checking bench against a transfer-level model
module tb_rr_mux2_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bit m_full, m_src, m_prio;
  logic [7:0] m_y;
  int m_c0, m_c1, s_c0, s_c1;
  rr_mux2_arbiter_if #(.WIDTH(8), .CNT_W(16)) ba ();
  rr_mux2_arbiter_if #(.WIDTH(8), .CNT_W(2)) bb ();
  assign bb.d0_valid = ba.d0_valid;
  assign bb.d0       = ba.d0;
  assign bb.d1_valid = ba.d1_valid;
  assign bb.d1       = ba.d1;
  assign bb.y_ready  = ba.y_ready;
  rr_mux2_arbiter #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ba));
  rr_mux2_arbiter #(.WIDTH(8), .CNT_W(2)) dut_s (.clk(clk), .rst(rst), .bus(bb));
  always #5 clk = ~clk;
  function automatic int grant_of();
    if (rst || (m_full && !ba.y_ready)) return -1;
    if (ba.d0_valid && ba.d1_valid) return int'(m_prio);
    if (ba.d0_valid) return 0;
    return ba.d1_valid ? 1 : -1;
  endfunction
  task automatic tick();
    int g = grant_of();
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_y = 0; m_src = 0; m_prio = 0;
      m_c0 = 0; m_c1 = 0; s_c0 = 0; s_c1 = 0;
    end else if (g >= 0) begin
      m_full = 1;
      m_y = (g == 1) ? ba.d1 : ba.d0;
      m_src = (g == 1);
      m_prio = (g == 0);
      if (g == 0) begin
        m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
        s_c0 = (s_c0 < 3) ? s_c0 + 1 : s_c0;
      end else begin
        m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
        s_c1 = (s_c1 < 3) ? s_c1 + 1 : s_c1;
      end
    end else if (m_full && ba.y_ready) m_full = 0;
    #1;
  endtask
  task automatic idle();
    ba.d0_valid = 0; ba.d1_valid = 0; ba.d0 = 0; ba.d1 = 0; ba.y_ready = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    ba.d0_valid = 1; ba.d1_valid = 1; ba.y_ready = 1;
    #1;
    checks++;
    if (ba.d0_ready !== 1'b0 || ba.d1_ready !== 1'b0 || bb.d0_ready !== 1'b0 || bb.d1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b%b%b want 0000", ba.d0_ready, ba.d1_ready, bb.d0_ready, bb.d1_ready);
    end
    tick(); tick();
    idle();
    rst = 0;
    #1;
    checks++;
    if (ba.y_valid !== 1'b0 || ba.y !== 8'h00 || ba.y_src !== 1'b0) begin
      errors++; $display("FAIL reset_out: got v=%b y=%h src=%b want 0 00 0", ba.y_valid, ba.y, ba.y_src);
    end
    checks++;
    if (ba.cnt0 !== 16'd0 || ba.cnt1 !== 16'd0 || ba.d0_ready !== 1'b0 || ba.d1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_cnt: got cnt0=%0d cnt1=%0d rdy=%b%b want 0 0 00", ba.cnt0, ba.cnt1, ba.d0_ready, ba.d1_ready);
    end
  endtask
  task automatic test_single();
    do_reset();
    ba.d0_valid = 1; ba.d0 = 8'hA5; ba.y_ready = 1;
    #1;
    checks++;
    if (ba.d0_ready !== 1'b1 || ba.d1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 10", ba.d0_ready, ba.d1_ready);
    end
    tick();
    ba.d0_valid = 0;
    checks++;
    if (ba.y_valid !== 1'b1 || ba.y !== 8'hA5 || ba.y_src !== 1'b0 || ba.cnt0 !== 16'd1 || ba.cnt1 !== 16'd0) begin
      errors++; $display("FAIL single_out: got v=%b y=%h src=%b cnt0=%0d cnt1=%0d want 1 a5 0 1 0", ba.y_valid, ba.y, ba.y_src, ba.cnt0, ba.cnt1);
    end
    ba.d0_valid = 1; ba.d1_valid = 1; ba.d1 = 8'h77;
    #1;
    checks++;
    if (ba.d0_ready !== 1'b0 || ba.d1_ready !== 1'b1) begin
      errors++; $display("FAIL single_prio: got %b%b want 01", ba.d0_ready, ba.d1_ready);
    end
  endtask
  task automatic test_alternate();
    logic [7:0] exp_y [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    do_reset();
    ba.d0_valid = 1; ba.d0 = 8'h11; ba.d1_valid = 1; ba.d1 = 8'h22; ba.y_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ba.y_valid !== 1'b1 || ba.y !== exp_y[i] || ba.y_src !== 1'(i % 2)) begin
        errors++; $display("FAIL alt_%0d: got v=%b y=%h src=%b want 1 %h %0d", i, ba.y_valid, ba.y, ba.y_src, exp_y[i], i % 2);
      end
    end
    checks++;
    if (ba.cnt0 !== 16'd2 || ba.cnt1 !== 16'd2) begin
      errors++; $display("FAIL alt_cnt: got %0d %0d want 2 2", ba.cnt0, ba.cnt1);
    end
  endtask
  task automatic test_stall();
    do_reset();
    ba.d0_valid = 1; ba.d0 = 8'h3C; ba.y_ready = 1;
    tick();
    ba.d0 = 8'h44; ba.d1_valid = 1; ba.d1 = 8'h55; ba.y_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ba.d0_ready !== 1'b0 || ba.d1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready_%0d: got %b%b want 00", i, ba.d0_ready, ba.d1_ready);
      end
      tick();
      checks++;
      if (ba.y_valid !== 1'b1 || ba.y !== 8'h3C || ba.cnt0 !== 16'd1 || ba.cnt1 !== 16'd0) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b y=%h cnt=%0d/%0d want 1 3c 1/0", i, ba.y_valid, ba.y, ba.cnt0, ba.cnt1);
      end
    end
    ba.y_ready = 1;
    #1;
    checks++;
    if (ba.d0_ready !== 1'b0 || ba.d1_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %b%b want 01", ba.d0_ready, ba.d1_ready);
    end
    tick();
    ba.d1_valid = 0;
    checks++;
    if (ba.y_valid !== 1'b1 || ba.y !== 8'h55 || ba.y_src !== 1'b1 || ba.cnt1 !== 16'd1) begin
      errors++; $display("FAIL stall_load: got v=%b y=%h src=%b cnt1=%0d want 1 55 1 1", ba.y_valid, ba.y, ba.y_src, ba.cnt1);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    ba.d1_valid = 1; ba.y_ready = 1;
    for (int i = 0; i < 5; i++) begin
      ba.d1 = 8'($urandom);
      tick();
      checks++;
      if (bb.cnt1 !== 2'((i + 1 > 3) ? 3 : i + 1) || bb.cnt0 !== 2'd0 || ba.cnt1 !== 16'(i + 1)) begin
        errors++; $display("FAIL sat_%0d: got small=%0d/%0d big=%0d want small=0/%0d big=%0d", i, bb.cnt0, bb.cnt1, ba.cnt1, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    ba.d0_valid = 1; ba.d0 = 8'h5A; ba.y_ready = 1;
    tick();
    ba.d0_valid = 0; ba.y_ready = 0;
    tick();
    checks++;
    if (ba.y_valid !== 1'b1 || ba.y !== 8'h5A) begin
      errors++; $display("FAIL mid_full: got v=%b y=%h want 1 5a", ba.y_valid, ba.y);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (ba.y_valid !== 1'b0 || ba.y !== 8'h00 || ba.y_src !== 1'b0 || ba.cnt0 !== 16'd0 || ba.cnt1 !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b y=%h src=%b cnt=%0d/%0d want 0 00 0 0/0", ba.y_valid, ba.y, ba.y_src, ba.cnt0, ba.cnt1);
    end
    ba.d0_valid = 1; ba.d1_valid = 1; ba.d1 = 8'h66; ba.y_ready = 1;
    #1;
    checks++;
    if (ba.d0_ready !== 1'b1 || ba.d1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_prio: got %b%b want 10", ba.d0_ready, ba.d1_ready);
    end
    tick();
    checks++;
    if (ba.y !== 8'h5A || ba.y_src !== 1'b0) begin
      errors++; $display("FAIL mid_first: got y=%h src=%b want 5a 0", ba.y, ba.y_src);
    end
  endtask
  task automatic test_random();
    int w0 = 0;
    int w1 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int g;
      if (!ba.d0_valid) begin ba.d0_valid = $urandom_range(0, 2) != 0; ba.d0 = 8'($urandom); end
      if (!ba.d1_valid) begin ba.d1_valid = $urandom_range(0, 2) != 0; ba.d1 = 8'($urandom); end
      ba.y_ready = $urandom_range(0, 3) != 0;
      #1;
      g = grant_of();
      checks++;
      if (ba.d0_ready !== (g == 0) || ba.d1_ready !== (g == 1) || bb.d0_ready !== (g == 0) || bb.d1_ready !== (g == 1)) begin
        errors++; $display("FAIL rand_ready_%0d: got %b%b want grant %0d", i, ba.d0_ready, ba.d1_ready, g);
      end
      if (g == 1 && ba.d0_valid) w0++;
      if (g == 0 && ba.d1_valid) w1++;
      if (g == 0) w0 = 0;
      if (g == 1) w1 = 0;
      checks++;
      if (w0 > 1 || w1 > 1) begin
        errors++; $display("FAIL rand_fair_%0d: got waits %0d/%0d want <=1", i, w0, w1);
      end
      tick();
      if (g == 0) ba.d0_valid = 0;
      if (g == 1) ba.d1_valid = 0;
      checks++;
      if (ba.y_valid !== m_full || ba.y !== m_y || ba.y_src !== m_src || ba.cnt0 !== 16'(m_c0) || ba.cnt1 !== 16'(m_c1)
          || bb.cnt0 !== 2'(s_c0) || bb.cnt1 !== 2'(s_c1) || bb.y !== m_y) begin
        errors++; $display("FAIL rand_out_%0d: got v=%b y=%h src=%b cnt=%0d/%0d small=%0d/%0d want %b %h %b %0d/%0d %0d/%0d",
          i, ba.y_valid, ba.y, ba.y_src, ba.cnt0, ba.cnt1, bb.cnt0, bb.cnt1, m_full, m_y, m_src, m_c0, m_c1, s_c0, s_c1);
      end
    end
  endtask
  initial begin
    idle();
    m_full = 0; m_y = 0; m_src = 0; m_prio = 0;
    m_c0 = 0; m_c1 = 0; s_c0 = 0; s_c1 = 0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
